// File: rtl/systolic_input_feeder.sv
// Operand buffer and diagonal-skew streamer for the NxN systolic array.
// Loads A row-wise then B column-wise, kicks the controller, then feeds 3N-2 skewed steps.
module systolic_input_feeder #(
  parameter int N  = 5,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic            init,
  output logic [N*DW-1:0] west_data,
  output logic [N*DW-1:0] north_data,
  output logic            feed_valid,
  output logic            busy,
  output logic            done
);

  localparam int BCW = $clog2(2*N);
  localparam int KW  = $clog2(3*N-2);
  localparam logic [BCW-1:0] BC_LAST = BCW'(2*N-1);
  localparam logic [KW-1:0]  K_LAST  = KW'(3*N-3);

  typedef enum logic [1:0] {LOAD, KICK, STREAM} state_t;

  state_t           state, state_nxt;
  logic [BCW-1:0]   bc, bc_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [DW-1:0]    a_mem [N][N];
  logic [DW-1:0]    b_mem [N][N];
  logic [N*DW-1:0]  west_nxt, north_nxt;
  logic             accept;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in LOAD and the offered beat is otherwise ignored.
  assign accept = in_valid && in_ready && (state == LOAD);

  always_comb begin
    state_nxt = state;
    bc_nxt    = bc;
    k_nxt     = k;
    case (state)
      LOAD: begin
        if (accept) begin
          if (bc == BC_LAST) begin
            state_nxt = KICK;
            bc_nxt    = '0;
          end else begin
            bc_nxt = bc + 1'b1;
          end
        end
      end
      KICK: begin
        state_nxt = STREAM;
        k_nxt     = '0;
      end
      STREAM: begin
        if (k == K_LAST) begin
          state_nxt = LOAD;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Step selection is computed from the next step so the edge lanes leave a register.
  always_comb begin
    west_nxt  = '0;
    north_nxt = '0;
    if (state_nxt == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N; d++) begin
          if (int'(k_nxt) - i == d) begin
            west_nxt[i*DW +: DW]  = a_mem[i][d];
            north_nxt[i*DW +: DW] = b_mem[d][i];
          end
        end
      end
    end
  end

  // Operand storage has no reset; a new load overwrites it beat by beat.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int m = 0; m < N; m++) begin
          if (bc == BCW'(r))     a_mem[r][m] <= in_data[m*DW +: DW];
          if (bc == BCW'(N + r)) b_mem[m][r] <= in_data[m*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      bc         <= '0;
      k          <= '0;
      in_ready   <= 1'b1;
      init       <= 1'b0;
      feed_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      west_data  <= '0;
      north_data <= '0;
    end else begin
      state      <= state_nxt;
      bc         <= bc_nxt;
      k          <= k_nxt;
      in_ready   <= (state_nxt == LOAD);
      init       <= (state_nxt == KICK);
      feed_valid <= (state_nxt == STREAM);
      busy       <= (state_nxt != LOAD);
      done       <= (state_nxt == STREAM) && (k_nxt == K_LAST);
      west_data  <= west_nxt;
      north_data <= north_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder: scoreboard of expected stream steps
// filled when a load is driven and drained whenever feed_valid is observed.
module tb_systolic_input_feeder;

  localparam int N     = 5;
  localparam int DW    = 8;
  localparam int LW    = N*DW;
  localparam int W     = 1 + 2*LW;
  localparam int STEPS = 3*N-2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [LW-1:0] in_data = '0;
  logic          in_ready, init, feed_valid, busy, done;
  logic [LW-1:0] west_data, north_data;

  int passed = 0;
  int total = 0;
  int ncyc = 0;
  int init_cnt = 0;
  int init_cyc = 0;
  int done_cyc = 0;
  int step_i = 0;
  int c0 = 0;
  int ic = 0;

  logic [W-1:0]  exp_q[$];
  int            ma [N][N];
  int            mb [N][N];
  logic [LW-1:0] obs_w [STEPS];
  logic [LW-1:0] obs_n [STEPS];
  logic          obs_d [STEPS];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  systolic_input_feeder #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .init       (init),
    .west_data  (west_data),
    .north_data (north_data),
    .feed_valid (feed_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [LW-1:0] pack(int l0, int l1, int l2, int l3, int l4);
    return {DW'(l4), DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  function automatic logic [LW-1:0] beat(int b);
    logic [LW-1:0] v = '0;
    for (int m = 0; m < N; m++)
      v[m*DW +: DW] = (b < N) ? DW'(ma[b][m]) : DW'(mb[m][b-N]);
    return v;
  endfunction

  // scoreboard: expected {done, west, north} for every step of the loaded matrices
  task automatic push_stream();
    for (int k = 0; k < STEPS; k++) begin
      logic [LW-1:0] w = '0;
      logic [LW-1:0] n = '0;
      for (int i = 0; i < N; i++) begin
        if (k - i >= 0 && k - i < N) begin
          w[i*DW +: DW] = DW'(ma[i][k-i]);
          n[i*DW +: DW] = DW'(mb[k-i][i]);
        end
      end
      exp_q.push_back({(k == STEPS-1), w, n});
    end
  endtask

  // advance to the next falling edge and observe the DUT there
  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (init) begin
      init_cnt++;
      init_cyc = ncyc;
    end
    if (init || feed_valid) check("init_fv_exclusive", W'(init & feed_valid), W'(0));
    if (feed_valid) begin
      if (step_i < STEPS) begin
        obs_w[step_i] = west_data;
        obs_n[step_i] = north_data;
        obs_d[step_i] = done;
      end
      if (exp_q.size() == 0) check("stream_unexpected", W'(feed_valid), W'(0));
      else check($sformatf("stream_step%0d", step_i), {done, west_data, north_data}, exp_q.pop_front());
      step_i++;
    end
    if (done) done_cyc = ncyc;
  endtask

  // driver: 2N beats, optional idle gaps after beats 2 and 7
  task automatic load(int gap_a, int gap_b);
    push_stream();
    step_i = 0;
    for (int b = 0; b < 2*N; b++) begin
      in_valid = 1'b1;
      in_data  = beat(b);
      tick();
      if (b == 2 || b == 7) begin
        in_valid = 1'b0;
        repeat ((b == 2) ? gap_a : gap_b) begin
          in_data = LW'({$urandom(), $urandom()});
          tick();
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(bit hold_valid);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 40) begin
      if (hold_valid) begin
        in_valid = 1'b1;
        in_data  = LW'({$urandom(), $urandom()});
      end
      tick();
      n++;
      if (hold_valid) check("blocked_in_ready", W'(in_ready), W'(0));
      seen = done;
    end
    in_valid = 1'b0;
    check("done_seen", W'(seen), W'(1));
    tick();
    check("ready_after_done", W'(in_ready), W'(1));
    check("busy_after_done", W'(busy), W'(0));
    check("queue_drained", W'(exp_q.size()), W'(0));
  endtask

  task automatic set_nominal();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 1 + 10*r + c;
        mb[r][c] = 101 + 10*r + c;
      end
  endtask

  task automatic set_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = $urandom_range(1, 255);
        mb[r][c] = $urandom_range(1, 255);
      end
  endtask

  initial begin
    // reset state
    tick();
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_init", W'(init), W'(0));
    check("rst_feed_valid", W'(feed_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_west", W'(west_data), W'(0));
    check("rst_north", W'(north_data), W'(0));
    rst_n = 1'b1;
    tick();

    // nominal load
    set_nominal();
    c0 = ncyc;
    load(0, 0);
    check("nom_init_latency", W'(init_cyc - c0), W'(2*N));
    check("nom_busy_kick", W'(busy), W'(1));
    wait_done(1'b0);
    check("nom_steps", W'(step_i), W'(STEPS));
    check("nom_done_after_init", W'(done_cyc - init_cyc), W'(STEPS));
    check("nom_w0", W'(obs_w[0]), W'(pack(1, 0, 0, 0, 0)));
    check("nom_n0", W'(obs_n[0]), W'(pack(101, 0, 0, 0, 0)));
    check("nom_w4", W'(obs_w[4]), W'(pack(5, 14, 23, 32, 41)));
    check("nom_n4", W'(obs_n[4]), W'(pack(141, 132, 123, 114, 105)));
    check("nom_w8", W'(obs_w[8]), W'(pack(0, 0, 0, 0, 45)));
    check("nom_n8", W'(obs_n[8]), W'(pack(0, 0, 0, 0, 145)));
    check("nom_w12", W'(obs_w[12]), W'(0));
    check("nom_n12", W'(obs_n[12]), W'(0));
    check("nom_done12", W'(obs_d[12]), W'(1));
    check("nom_done11", W'(obs_d[11]), W'(0));
    check("nom_init_count", W'(init_cnt), W'(1));

    // backpressure gaps
    c0 = ncyc;
    load(3, 3);
    check("gap_init_latency", W'(init_cyc - c0), W'(2*N + 6));
    wait_done(1'b0);
    check("gap_init_count", W'(init_cnt), W'(2));

    // blocked input during KICK/STREAM
    set_random();
    load(0, 0);
    wait_done(1'b1);
    check("blk_init_count", W'(init_cnt), W'(3));

    // back-to-back, second load starts right after done
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 7;
        mb[r][c] = 7;
      end
    load(0, 0);
    check("b2b_init_gap", W'(init_cyc - done_cyc), W'(2*N + 1));
    wait_done(1'b0);
    check("b2b_w4", W'(obs_w[4]), W'(pack(7, 7, 7, 7, 7)));
    check("b2b_n4", W'(obs_n[4]), W'(pack(7, 7, 7, 7, 7)));

    // reset mid-stream at step 6
    set_random();
    load(0, 0);
    for (int n = 0; n < 20 && step_i < 7; n++) tick();
    check("mid_reached_step6", W'(step_i), W'(7));
    rst_n = 1'b0;
    #1;
    check("mid_rst_feed_valid", W'(feed_valid), W'(0));
    check("mid_rst_west", W'(west_data), W'(0));
    check("mid_rst_north", W'(north_data), W'(0));
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    check("mid_rst_busy", W'(busy), W'(0));
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    set_random();
    load(0, 0);
    wait_done(1'b0);

    // partial load then reset
    set_random();
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_data  = beat(b);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ic = init_cnt;
    set_random();
    c0 = ncyc;
    load(0, 0);
    check("part_init_latency", W'(init_cyc - c0), W'(2*N));
    wait_done(1'b0);
    check("part_init_count", W'(init_cnt - ic), W'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
